// File: rtl/ram_dp_arbiter.sv
// Two-requester arbiter for a simple dual-port RAM: one write and one read grant
// per cycle, each with its own round-robin pointer, plus a read-after-write stall.
module ram_dp_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  logic                  w_wr_c0, w_wr_c1, w_rd_c0, w_rd_c1;
  logic                  w_wr_sel, w_rd_sel;
  logic                  w_wr_gnt, w_rd_gnt, w_hazard;
  logic [ADDR_WIDTH-1:0] w_wr_addr, w_rd_addr;

  // Pointers hold the requester served by the last grant (0 = m0, 1 = m1).
  logic                  r_wr_last, r_rd_last;
  logic                  r_rd_pend, r_rd_sel;
  logic [ADDR_WIDTH-1:0] r_rd_addr;

  assign w_wr_c0 = m0_req & m0_we;
  assign w_wr_c1 = m1_req & m1_we;
  assign w_rd_c0 = m0_req & ~m0_we;
  assign w_rd_c1 = m1_req & ~m1_we;

  always_comb begin
    w_wr_sel = w_wr_c1;
    w_rd_sel = w_rd_c1;
    if (w_wr_c0 && w_wr_c1) w_wr_sel = ~r_wr_last;
    if (w_rd_c0 && w_rd_c1) w_rd_sel = ~r_rd_last;
  end

  assign w_wr_addr = w_wr_sel ? m1_addr : m0_addr;
  assign w_rd_addr = w_rd_sel ? m1_addr : m0_addr;

  // A read hitting the address being written this edge waits one cycle so it sees the new data.
  assign w_wr_gnt = HRESETn & (w_wr_c0 | w_wr_c1);
  assign w_hazard = w_wr_gnt & (w_rd_addr == w_wr_addr);
  assign w_rd_gnt = HRESETn & (w_rd_c0 | w_rd_c1) & ~w_hazard;

  assign m0_gnt = (w_wr_gnt & ~w_wr_sel) | (w_rd_gnt & ~w_rd_sel);
  assign m1_gnt = (w_wr_gnt &  w_wr_sel) | (w_rd_gnt &  w_rd_sel);

  assign ram_we         = w_wr_gnt;
  assign ram_write_addr = w_wr_addr;
  assign ram_data       = w_wr_sel ? m1_wdata : m0_wdata;
  assign ram_read_addr  = w_rd_gnt ? w_rd_addr : r_rd_addr;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wr_last <= 1'b1;
      r_rd_last <= 1'b1;
      r_rd_pend <= 1'b0;
      r_rd_sel  <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      r_rd_pend <= w_rd_gnt;
      if (w_wr_gnt) r_wr_last <= w_wr_sel;
      if (w_rd_gnt) begin
        r_rd_last <= w_rd_sel;
        r_rd_sel  <= w_rd_sel;
        r_rd_addr <= w_rd_addr;
      end
    end
  end

  assign m0_rvalid = r_rd_pend & ~r_rd_sel;
  assign m1_rvalid = r_rd_pend &  r_rd_sel;
  assign m0_rdata  = ram_q;
  assign m1_rdata  = ram_q;

endmodule

// File: tb/tb_ram_dp_arbiter.sv
// Bench for ram_dp_arbiter: directed vector table, reset corner cases and
// randomized traffic checked against a cycle-level reference model.
module tb_ram_dp_arbiter;
  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;
  localparam logic I = 1'b1;
  localparam logic O = 1'b0;

  logic          HCLK    = 1'b0;
  logic          HRESETn = 1'b0;
  logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, ram_we;
  logic [DW-1:0] m0_rdata, m1_rdata, ram_data;
  logic [DW-1:0] ram_q = '0;
  logic [AW-1:0] ram_write_addr, ram_read_addr;

  int n_tests = 0;
  int n_fail  = 0;

  ram_dp_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_we(ram_we), .ram_write_addr(ram_write_addr), .ram_data(ram_data),
    .ram_read_addr(ram_read_addr), .ram_q(ram_q)
  );

  always #5 HCLK = ~HCLK;

  // Behavioural RAM with registered read; contents seeded on the first edge.
  logic [DW-1:0] ram_mem [DEPTH];
  logic          ram_ready = 1'b0;
  always @(posedge HCLK) begin
    if (!ram_ready) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= DW'(i * 7 + 3);
      ram_ready <= 1'b1;
    end else if (ram_we) begin
      ram_mem[ram_write_addr] <= ram_data;
    end
    ram_q <= ram_mem[ram_read_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: grant rules from the arbitration description, memory as a plain array.
  logic [DW-1:0] exp_mem [DEPTH];
  int            mdl_wr_last = 1, mdl_rd_last = 1;
  bit            mdl_pend = 1'b0;
  int            mdl_pend_who = 0;
  logic [DW-1:0] mdl_pend_data = '0;
  logic [AW-1:0] mdl_last_ra = '0;

  function automatic int pick(input bit c0, input bit c1, input int last);
    if (c0 && c1) return 1 - last;
    if (c0) return 0;
    if (c1) return 1;
    return -1;
  endfunction

  always @(negedge HCLK) begin
    int            wg, rg;
    logic [AW-1:0] ma [2];
    logic [DW-1:0] md [2];
    if (!HRESETn) begin
      check("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
      check("rst_ram_we", {31'd0, ram_we}, 32'd0);
      check("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
      mdl_wr_last = 1;
      mdl_rd_last = 1;
      mdl_pend    = 1'b0;
      mdl_last_ra = '0;
    end else begin
      ma[0] = m0_addr;  ma[1] = m1_addr;
      md[0] = m0_wdata; md[1] = m1_wdata;
      wg = pick(m0_req && m0_we, m1_req && m1_we, mdl_wr_last);
      rg = pick(m0_req && !m0_we, m1_req && !m1_we, mdl_rd_last);
      if (wg >= 0 && rg >= 0 && ma[rg] == ma[wg]) rg = -1;
      check("mdl_m0_gnt", {31'd0, m0_gnt}, {31'd0, (wg == 0 || rg == 0)});
      check("mdl_m1_gnt", {31'd0, m1_gnt}, {31'd0, (wg == 1 || rg == 1)});
      check("mdl_ram_we", {31'd0, ram_we}, {31'd0, (wg >= 0)});
      if (wg >= 0) begin
        check("mdl_waddr", {26'd0, ram_write_addr}, {26'd0, ma[wg]});
        check("mdl_wdata", {24'd0, ram_data}, {24'd0, md[wg]});
      end
      check("mdl_raddr", {26'd0, ram_read_addr}, {26'd0, (rg >= 0) ? ma[rg] : mdl_last_ra});
      check("mdl_m0_rvalid", {31'd0, m0_rvalid}, {31'd0, (mdl_pend && mdl_pend_who == 0)});
      check("mdl_m1_rvalid", {31'd0, m1_rvalid}, {31'd0, (mdl_pend && mdl_pend_who == 1)});
      if (mdl_pend)
        check("mdl_rdata", {24'd0, (mdl_pend_who == 0) ? m0_rdata : m1_rdata}, {24'd0, mdl_pend_data});
      mdl_pend = (rg >= 0);
      if (rg >= 0) begin
        mdl_pend_who  = rg;
        mdl_pend_data = exp_mem[ma[rg]];
        mdl_rd_last   = rg;
        mdl_last_ra   = ma[rg];
      end
      if (wg >= 0) begin
        exp_mem[ma[wg]] = md[wg];
        mdl_wr_last     = wg;
      end
    end
  end

  typedef struct {
    logic r0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic r1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic g0, g1, rv0, rv1; logic [DW-1:0] rd;
  } vec_t;

  function automatic vec_t mk(input logic r0, w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic r1, w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input logic g0, g1, rv0, rv1, input logic [DW-1:0] rd);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.rv0 = rv0; v.rv1 = rv1; v.rd = rd;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
  endtask

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  vec_t tbl [19];
  vec_t idle;
  bit   g0_seen = 1'b0, g1_seen = 1'b0;

  initial begin
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = DW'(i * 7 + 3);
    idle = mk(O, O, '0, '0, O, O, '0, '0, O, O, O, O, '0);
    // Solo write then read, then read-back
    tbl[0]  = mk(I, I, 6'h10, 8'hA5, O, O, '0, '0, I, O, O, O, '0);
    tbl[1]  = mk(I, O, 6'h10, '0,    O, O, '0, '0, I, O, O, O, '0);
    tbl[2]  = mk(O, O, '0, '0,       O, O, '0, '0, O, O, I, O, 8'hA5);
    // Write contention: last write was m0, so m1 goes first
    tbl[3]  = mk(I, I, 6'h01, 8'h11, I, I, 6'h02, 8'h22, O, I, O, O, '0);
    tbl[4]  = mk(I, I, 6'h01, 8'h11, I, I, 6'h02, 8'h22, I, O, O, O, '0);
    tbl[5]  = mk(I, I, 6'h01, 8'h11, I, I, 6'h02, 8'h22, O, I, O, O, '0);
    tbl[6]  = mk(I, I, 6'h01, 8'h11, I, I, 6'h02, 8'h22, I, O, O, O, '0);
    // Read contention: last read was m0, so m1 goes first
    tbl[7]  = mk(I, O, 6'h01, '0, I, O, 6'h02, '0, O, I, O, O, '0);
    tbl[8]  = mk(I, O, 6'h01, '0, I, O, 6'h02, '0, I, O, O, I, 8'h22);
    tbl[9]  = mk(I, O, 6'h01, '0, I, O, 6'h02, '0, O, I, I, O, 8'h11);
    tbl[10] = mk(O, O, '0, '0,    O, O, '0, '0,    O, O, O, I, 8'h22);
    // Concurrent write and read; address 0x06 still holds its seed value 0x2D
    tbl[11] = mk(I, I, 6'h05, 8'h3C, I, O, 6'h06, '0, I, I, O, O, '0);
    // Hazard: read of 0x08 stalls behind the write, then returns new data
    tbl[12] = mk(I, I, 6'h08, 8'h77, I, O, 6'h08, '0, I, O, O, I, 8'h2D);
    tbl[13] = mk(O, O, '0, '0,       I, O, 6'h08, '0, O, I, O, O, '0);
    tbl[14] = mk(O, O, '0, '0,       O, O, '0, '0,    O, O, O, I, 8'h77);
    // Back-to-back reads by m0
    tbl[15] = mk(I, O, 6'h05, '0, O, O, '0, '0, I, O, O, O, '0);
    tbl[16] = mk(I, O, 6'h06, '0, O, O, '0, '0, I, O, I, O, 8'h3C);
    tbl[17] = mk(I, O, 6'h10, '0, O, O, '0, '0, I, O, I, O, 8'h2D);
    tbl[18] = mk(O, O, '0, '0,    O, O, '0, '0, O, O, I, O, 8'hA5);

    // Reset held with a pending write request
    drive(mk(I, I, 6'h3F, 8'h99, O, O, '0, '0, O, O, O, O, '0));
    repeat (3) @(negedge HCLK);
    check("rst_hold_m0_gnt", {31'd0, m0_gnt}, 32'd0);
    check("rst_hold_ram_we", {31'd0, ram_we}, 32'd0);
    next_cycle();
    HRESETn = 1'b1;
    @(negedge HCLK);
    check("rst_rel_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    check("rst_rel_ram_we", {31'd0, ram_we}, 32'd1);
    next_cycle();

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i]);
      @(negedge HCLK);
      check($sformatf("vec%0d_m0_gnt", i), {31'd0, m0_gnt}, {31'd0, tbl[i].g0});
      check($sformatf("vec%0d_m1_gnt", i), {31'd0, m1_gnt}, {31'd0, tbl[i].g1});
      check($sformatf("vec%0d_m0_rvalid", i), {31'd0, m0_rvalid}, {31'd0, tbl[i].rv0});
      check($sformatf("vec%0d_m1_rvalid", i), {31'd0, m1_rvalid}, {31'd0, tbl[i].rv1});
      if (tbl[i].rv0) check($sformatf("vec%0d_m0_rdata", i), {24'd0, m0_rdata}, {24'd0, tbl[i].rd});
      if (tbl[i].rv1) check($sformatf("vec%0d_m1_rdata", i), {24'd0, m1_rdata}, {24'd0, tbl[i].rd});
      next_cycle();
    end

    // Reset the cycle after a read grant: that read never returns
    drive(mk(O, O, '0, '0, I, O, 6'h02, '0, O, O, O, O, '0));
    @(negedge HCLK);
    check("midrst_m1_gnt", {31'd0, m1_gnt}, 32'd1);
    next_cycle();
    drive(idle);
    HRESETn = 1'b0;
    @(negedge HCLK);
    check("midrst_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    next_cycle();
    HRESETn = 1'b1;
    @(negedge HCLK);
    check("midrst_after_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    next_cycle();

    // Randomized traffic on a narrow address range so hazards occur often
    for (int c = 0; c < 800; c++) begin
      if (!m0_req || g0_seen) begin
        m0_req   = ($urandom_range(0, 9) < 7);
        m0_we    = 1'($urandom_range(0, 1));
        m0_addr  = AW'($urandom_range(0, 7));
        m0_wdata = DW'($urandom);
      end
      if (!m1_req || g1_seen) begin
        m1_req   = ($urandom_range(0, 9) < 7);
        m1_we    = 1'($urandom_range(0, 1));
        m1_addr  = AW'($urandom_range(0, 7));
        m1_wdata = DW'($urandom);
      end
      @(negedge HCLK);
      g0_seen = m0_gnt;
      g1_seen = m1_gnt;
      next_cycle();
    end

    drive(idle);
    repeat (2) @(negedge HCLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_dp_arbiter.md
Name: ram_dp_arbiter

Overview:
- Shares one simple dual-port block RAM between two requesters, m0 and m1. The RAM has one write port, one read port and a registered read with 1-cycle latency.
- Each cycle the arbiter grants the RAM write port to at most one requester and the RAM read port to at most one requester.
- The two grants can go to different requesters in the same cycle.
- Sits between the RAM instance and its clients, e.g. CPU-side bus bridge and SPI/DMA engine.

Parameters:
DATA_WIDTH, 8, RAM word width
ADDR_WIDTH, 6, RAM address width

Ports:
HCLK  in  1  single clock; all state on rising edge
HRESETn  in  1  asynchronous active-low reset
m0_req  in  1  m0 access request; held with fields stable until m0_gnt
m0_we  in  1  1 = write, 0 = read
m0_addr  in  ADDR_WIDTH  m0 address
m0_wdata  in  DATA_WIDTH  m0 write data
m0_gnt  out  1  combinational grant; access performed this edge
m0_rvalid  out  1  m0_rdata valid (cycle after read grant)
m0_rdata  out  DATA_WIDTH  read data for m0
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0 for requester m1
ram_we  out  1  RAM write enable
ram_write_addr  out  ADDR_WIDTH  RAM write address
ram_data  out  DATA_WIDTH  RAM write data
ram_read_addr  out  ADDR_WIDTH  RAM read address
ram_q  in  DATA_WIDTH  RAM registered read data

Behaviour:
- Reset: clock is HCLK; reset is HRESETn, asynchronous, active-low.
  - While HRESETn=0: mX_gnt=0, ram_we=0, mX_rvalid=0, both round-robin pointers = m0-priority.
  - Reset mid-operation drops any pending rvalid. No write is issued while in reset.
- Write arbitration:
  - Write candidates are requesters with req=1 and we=1.
  - One candidate: it is granted.
  - Two candidates: the requester not served by the last write grant wins (wr_last pointer).
  - wr_last updates only on a write grant.
- Read arbitration:
  - Read candidates are requesters with req=1 and we=0.
  - Same round-robin scheme, using an independent rd_last pointer.
- Read-write hazard:
  - A granted write and a candidate read with equal addresses in the same cycle: the read is not granted that cycle (stalled) and rd_last is not updated.
  - The read is granted next cycle and returns the new data.
- Concurrency: one write grant and one non-hazard read grant can be issued in the same cycle, to the same or different requesters. A single requester has only one request, so it gets at most one grant per cycle.
- RAM drive:
  - ram_we = write grant.
  - ram_write_addr and ram_data are muxed from the write winner.
  - ram_read_addr is muxed from the read winner, or holds the last value when there is no read grant.
  - Outputs are combinational from the requests and registered pointers.
- Read return:
  - Registered rd_sel/rd_pend are captured on the read grant.
  - Next cycle, mX_rvalid=1 for the selected requester only, for exactly 1 cycle.
  - mX_rdata = ram_q for both requesters; valid only when the matching rvalid is 1.
- Latency: gnt is issued in the same cycle as req when uncontended. Read data arrives 1 cycle after the grant edge.
- Back-to-back reads by one requester every cycle are allowed; throughput is 1 read/cycle.
- Starvation bound: a continuously asserted request waits at most 2 cycles when contended, plus 1 cycle for a hazard stall.
- A requester dropping req before gnt is a protocol violation; behaviour is undefined but the arbiter must not lock up.

Test Plan:
- Reset: hold HRESETn=0 with m0_req=1,we=1 -> ram_we=0, all gnt/rvalid=0. Release -> m0_gnt=1, ram_we=1 same cycle.
- Solo traffic: m0 writes 0xA5 @0x10, then reads 0x10 -> m0_gnt on each, m0_rvalid=1 with m0_rdata=0xA5 one cycle after read grant, m1_rvalid=0.
- Write contention: both write continuously (m0 @0x01=0x11, m1 @0x02=0x22) -> grants alternate m0,m1,m0..., ram_we=1 every cycle.
- Read contention: both read continuously from preloaded addresses -> rvalid alternates m0,m1, each with its own address data, and rd_last is independent of write history.
- Mixed concurrency: m0 writes 0x3C @0x05 while m1 reads 0x06 -> both gnt=1 same cycle, m1_rdata = old value at 0x06 next cycle.
- Hazard: m0 writes 0x77 @0x08 while m1 reads 0x08 -> m1_gnt=0 that cycle, =1 next, m1_rdata=0x77.
- Reset mid-read: assert HRESETn=0 the cycle after a read grant -> no rvalid is ever produced for that read.
